// File: rtl/flick_pkg.sv
// flick_pkg
// Shared definitions for the push-button debouncer ("flick" generator):
// FSM state encoding and the default debounce / long-press lengths.
// No ports; imported by flick_debounce and its testbench.
package flick_pkg;

    // Default number of consecutive synchronized samples needed to accept
    // a change in button level.
    localparam int DEBOUNCE_CYCLES_DEF = 4;

    // Default number of cycles spent in PRESSED before long_press fires.
    localparam int LONG_CYCLES_DEF = 64;

    // Debouncer FSM states; the encoding is visible on dbg_state.
    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_PRESSED      = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } state_e;

endpackage

// File: rtl/flick_debounce_if.sv
// flick_debounce_if
// Groups the button input and the debouncer outputs into one bundle.
//   btn_raw    : raw, bouncing, asynchronous push-button level (active-high)
//   flick      : one-cycle pulse per accepted press
//   long_press : one-cycle pulse when a press is held long enough
//   btn_level  : debounced button level
//   dbg_state  : current debouncer FSM state
// The slave modport is the debouncer's view; the master modport is the
// view of whatever drives the button and consumes the pulses.
interface flick_debounce_if;

    logic       btn_raw;
    logic       flick;
    logic       long_press;
    logic       btn_level;
    logic [1:0] dbg_state;

    modport master (
        output btn_raw,
        input  flick,
        input  long_press,
        input  btn_level,
        input  dbg_state
    );

    modport slave (
        input  btn_raw,
        output flick,
        output long_press,
        output btn_level,
        output dbg_state
    );

endinterface

// File: rtl/Ex_1.sv
// Ex_1
// Small LED chaser: a single lit LED that steps one position to the left
// on every flick pulse, wrapping around from the top LED to the bottom.
//   clk     : clock
//   reset_n : synchronous active-low reset, LED 0 lit after reset
//   flick   : one-cycle step request
//   leds    : one-hot LED pattern
module Ex_1 (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       flick,
    output logic [7:0] leds
);

    logic [7:0] leds_q;
    logic [7:0] leds_d;

    always_comb begin
        leds_d = leds_q;
        if (flick) begin
            leds_d = {leds_q[6:0], leds_q[7]};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            leds_q <= 8'h01;
        end else begin
            leds_q <= leds_d;
        end
    end

    assign leds = leds_q;

endmodule

// File: rtl/sync_2ff.sv
// sync_2ff
// Two-flop synchronizer for bringing a single asynchronous level into the
// clk domain. Generic so it can be reused for any raw input.
//   clk     : destination clock
//   reset_n : synchronous active-low reset, clears both flops
//   d       : asynchronous input level
//   q       : synchronized level, two clk edges behind d
module sync_2ff (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic meta_d;
    logic sync_q;
    logic sync_d;

    // Plain shift chain: the first flop may go metastable, the second
    // gives it a full cycle to settle before anyone looks at it.
    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/flick_debounce.sv
// flick_debounce
// Debounces a raw push-button and turns each accepted press into a single
// flick pulse, plus a single long_press pulse if the press is held.
//   clk     : clock, all logic on the rising edge
//   reset_n : synchronous active-low reset
//   bus     : slave side of flick_debounce_if
//             (btn_raw in; flick, long_press, btn_level, dbg_state out)
// Parameters:
//   DEBOUNCE_CYCLES : samples needed to accept a level change (2..255)
//   LONG_CYCLES     : cycles in PRESSED before long_press (> DEBOUNCE_CYCLES,
//                     at most 65535)
module flick_debounce
    import flick_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int LONG_CYCLES     = LONG_CYCLES_DEF
) (
    input  logic                clk,
    input  logic                reset_n,
    flick_debounce_if.slave     bus
);

    // Counters only ever need to reach PARAM-1, so $clog2(PARAM) bits fit.
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
    localparam int LP_W = $clog2(LONG_CYCLES);

    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1);
    localparam logic [LP_W-1:0] LP_LAST = LP_W'(LONG_CYCLES - 1);

    logic btn_s;

    state_e            state_q;
    state_e            state_d;
    logic [DB_W-1:0]   db_cnt_q;
    logic [DB_W-1:0]   db_cnt_d;
    logic [LP_W-1:0]   lp_cnt_q;
    logic [LP_W-1:0]   lp_cnt_d;
    logic [LP_W-1:0]   lp_inc;
    logic              flick_q;
    logic              flick_d;
    logic              long_press_q;
    logic              long_press_d;
    logic              btn_level_q;
    logic              btn_level_d;

    sync_2ff u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (bus.btn_raw),
        .q       (btn_s)
    );

    assign lp_inc = lp_cnt_q + LP_W'(1);

    // Next-state logic. The debounce counter tracks how many consecutive
    // samples have agreed with the candidate level; the long-press counter
    // runs while PRESSED and parks at LONG_CYCLES-1, so long_press can only
    // fire on the single cycle the counter first reaches that value. A
    // return from RELEASE_WAIT leaves it untouched, so a release glitch
    // cannot re-arm it.
    always_comb begin
        state_d      = state_q;
        db_cnt_d     = db_cnt_q;
        lp_cnt_d     = lp_cnt_q;
        flick_d      = 1'b0;
        long_press_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (btn_s) begin
                    state_d  = ST_PRESS_WAIT;
                    db_cnt_d = DB_ONE;
                end else begin
                    db_cnt_d = '0;
                end
            end

            ST_PRESS_WAIT: begin
                if (!btn_s) begin
                    state_d  = ST_IDLE;
                    db_cnt_d = '0;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d  = ST_PRESSED;
                    db_cnt_d = '0;
                    lp_cnt_d = '0;
                    flick_d  = 1'b1;
                end else begin
                    db_cnt_d = db_cnt_q + DB_ONE;
                end
            end

            ST_PRESSED: begin
                if (lp_cnt_q != LP_LAST) begin
                    lp_cnt_d     = lp_inc;
                    long_press_d = (lp_inc == LP_LAST);
                end
                if (!btn_s) begin
                    state_d  = ST_RELEASE_WAIT;
                    db_cnt_d = DB_ONE;
                end
            end

            ST_RELEASE_WAIT: begin
                if (btn_s) begin
                    state_d  = ST_PRESSED;
                    db_cnt_d = '0;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d  = ST_IDLE;
                    db_cnt_d = '0;
                end else begin
                    db_cnt_d = db_cnt_q + DB_ONE;
                end
            end

            default: begin
                state_d  = ST_IDLE;
                db_cnt_d = '0;
            end
        endcase

        btn_level_d = (state_d == ST_PRESSED) || (state_d == ST_RELEASE_WAIT);
    end

    // State, counters and registered outputs. Reset takes effect on the
    // edge itself, so any pulse that would have been produced is dropped.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            db_cnt_q     <= '0;
            lp_cnt_q     <= '0;
            flick_q      <= 1'b0;
            long_press_q <= 1'b0;
            btn_level_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            db_cnt_q     <= db_cnt_d;
            lp_cnt_q     <= lp_cnt_d;
            flick_q      <= flick_d;
            long_press_q <= long_press_d;
            btn_level_q  <= btn_level_d;
        end
    end

    assign bus.flick      = flick_q;
    assign bus.long_press = long_press_q;
    assign bus.btn_level  = btn_level_q;
    assign bus.dbg_state  = state_q;

endmodule

// File: tb/tb_flick_debounce.sv
// tb_flick_debounce
// Self-checking bench for flick_debounce (DEBOUNCE_CYCLES=4, LONG_CYCLES=16)
// with its flick output driving an Ex_1 LED chaser.
module tb_flick_debounce;
    import flick_pkg::*;

    localparam int DBC = 4;
    localparam int LPC = 16;

    // One cycle of stimulus and the outputs expected just after that edge.
    typedef struct packed {
        logic       rst_n;
        logic       raw;
        logic       flick;
        logic       long_press;
        logic       level;
        logic [1:0] state;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] leds;

    int checks = 0;
    int errors = 0;

    vec_t tbl[$];
    vec_t exp_q[$];

    flick_debounce_if dut_if ();

    flick_debounce #(
        .DEBOUNCE_CYCLES (DBC),
        .LONG_CYCLES     (LPC)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (dut_if.slave)
    );

    Ex_1 u_chaser (
        .clk     (clk),
        .reset_n (reset_n),
        .flick   (dut_if.flick),
        .leds    (leds)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic b, input logic f,
                                input logic l, input logic v, input logic [1:0] s);
        vec_t t;
        t = {r, b, f, l, v, s};
        return t;
    endfunction

    task automatic check_eq(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Pop the oldest expectation and compare it with what the DUT shows now.
    task automatic checkOutput(input string name, input int idx);
        vec_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("[TB] FAIL %s[%0d]: scoreboard empty", name, idx);
            return;
        end
        e = exp_q.pop_front();
        if ({dut_if.flick, dut_if.long_press, dut_if.btn_level, dut_if.dbg_state} !==
            {e.flick, e.long_press, e.level, e.state}) begin
            errors++;
            $display("[TB] FAIL %s[%0d]: flick/long/level/state got %b/%b/%b/%0d, expected %b/%b/%b/%0d",
                     name, idx, dut_if.flick, dut_if.long_press, dut_if.btn_level,
                     dut_if.dbg_state, e.flick, e.long_press, e.level, e.state);
        end
    endtask

    // Drive one vector between edges, record its expectation, then look at
    // the outputs 1 ns after the edge that consumes it.
    task automatic applyStimulus(input string name, input int idx, input vec_t v);
        @(negedge clk);
        reset_n        = v.rst_n;
        dut_if.btn_raw = v.raw;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        checkOutput(name, idx);
    endtask

    task automatic run_table(input string name);
        for (int i = 0; i < tbl.size(); i++) begin
            applyStimulus(name, i, tbl[i]);
        end
        tbl.delete();
    endtask

    initial begin
        int flick_cnt;
        int long_cnt;
        int flick_at;
        int long_at;
        int overlap;

        dut_if.btn_raw = 1'b0;

        // Reset, then a clean press: raw high from edge 0, flick after
        // edge 5, then release and the four-sample release debounce.
        tbl.push_back(mk(0, 0, 0, 0, 0, 2'd0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 2'd0));
        tbl.push_back(mk(1, 1, 0, 0, 0, 2'd0));   // edge 0
        tbl.push_back(mk(1, 1, 0, 0, 0, 2'd0));   // edge 1
        tbl.push_back(mk(1, 1, 0, 0, 0, 2'd1));   // edge 2
        tbl.push_back(mk(1, 1, 0, 0, 0, 2'd1));
        tbl.push_back(mk(1, 1, 0, 0, 0, 2'd1));
        tbl.push_back(mk(1, 1, 1, 0, 1, 2'd2));   // edge 5: flick
        tbl.push_back(mk(1, 1, 0, 0, 1, 2'd2));
        tbl.push_back(mk(1, 0, 0, 0, 1, 2'd2));   // edge 7: release
        tbl.push_back(mk(1, 0, 0, 0, 1, 2'd2));
        tbl.push_back(mk(1, 0, 0, 0, 1, 2'd3));
        tbl.push_back(mk(1, 0, 0, 0, 1, 2'd3));
        tbl.push_back(mk(1, 0, 0, 0, 1, 2'd3));
        tbl.push_back(mk(1, 0, 0, 0, 0, 2'd0));   // edge 12: idle again
        run_table("clean");
        check_eq("chaser_after_clean", int'(leds), 8'h02);

        // Bounce 1,1,0,1,1 samples: never reaches PRESSED.
        tbl.push_back(mk(1, 1, 0, 0, 0, 2'd0));
        tbl.push_back(mk(1, 1, 0, 0, 0, 2'd0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 2'd1));
        tbl.push_back(mk(1, 1, 0, 0, 0, 2'd1));
        tbl.push_back(mk(1, 1, 0, 0, 0, 2'd0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 2'd1));
        tbl.push_back(mk(1, 0, 0, 0, 0, 2'd1));
        tbl.push_back(mk(1, 0, 0, 0, 0, 2'd0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 2'd0));
        run_table("bounce");
        check_eq("chaser_after_bounce", int'(leds), 8'h02);

        // Press, then a two-sample release glitch: 2 -> 3 -> 2, no flick.
        tbl.push_back(mk(1, 1, 0, 0, 0, 2'd0));
        tbl.push_back(mk(1, 1, 0, 0, 0, 2'd0));
        tbl.push_back(mk(1, 1, 0, 0, 0, 2'd1));
        tbl.push_back(mk(1, 1, 0, 0, 0, 2'd1));
        tbl.push_back(mk(1, 1, 0, 0, 0, 2'd1));
        tbl.push_back(mk(1, 1, 1, 0, 1, 2'd2));
        tbl.push_back(mk(1, 1, 0, 0, 1, 2'd2));
        tbl.push_back(mk(1, 0, 0, 0, 1, 2'd2));
        tbl.push_back(mk(1, 0, 0, 0, 1, 2'd2));
        tbl.push_back(mk(1, 1, 0, 0, 1, 2'd3));
        tbl.push_back(mk(1, 1, 0, 0, 1, 2'd3));
        tbl.push_back(mk(1, 1, 0, 0, 1, 2'd2));
        tbl.push_back(mk(1, 1, 0, 0, 1, 2'd2));
        run_table("glitch");
        check_eq("chaser_after_glitch", int'(leds), 8'h04);

        // Reset from PRESSED, then reset while in PRESS_WAIT with raw held
        // high: the full debounce is needed again, flick 6 edges later.
        tbl.push_back(mk(0, 0, 0, 0, 0, 2'd0));
        tbl.push_back(mk(1, 1, 0, 0, 0, 2'd0));
        tbl.push_back(mk(1, 1, 0, 0, 0, 2'd0));
        tbl.push_back(mk(1, 1, 0, 0, 0, 2'd1));
        tbl.push_back(mk(0, 1, 0, 0, 0, 2'd0));   // reset edge in PRESS_WAIT
        tbl.push_back(mk(1, 1, 0, 0, 0, 2'd0));   // release +1
        tbl.push_back(mk(1, 1, 0, 0, 0, 2'd0));
        tbl.push_back(mk(1, 1, 0, 0, 0, 2'd1));
        tbl.push_back(mk(1, 1, 0, 0, 0, 2'd1));
        tbl.push_back(mk(1, 1, 0, 0, 0, 2'd1));
        tbl.push_back(mk(1, 1, 1, 0, 1, 2'd2));   // release +6: flick
        tbl.push_back(mk(1, 1, 0, 0, 1, 2'd2));
        run_table("midreset");
        check_eq("chaser_after_midreset", int'(leds), 8'h02);
        check_eq("scoreboard_drained", exp_q.size(), 0);

        // Long hold: 300 ns high after a reset, then release.
        @(negedge clk);
        reset_n        = 1'b0;
        dut_if.btn_raw = 1'b0;
        @(negedge clk);
        reset_n   = 1'b1;
        flick_cnt = 0;
        long_cnt  = 0;
        flick_at  = -1;
        long_at   = -1;
        overlap   = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            dut_if.btn_raw = (i < 30);
            @(posedge clk);
            #1;
            if (dut_if.flick) begin
                flick_cnt++;
                flick_at = i;
            end
            if (dut_if.long_press) begin
                long_cnt++;
                long_at = i;
            end
            if (dut_if.flick && dut_if.long_press) begin
                overlap++;
            end
        end
        check_eq("long_flick_count", flick_cnt, 1);
        check_eq("long_flick_edge", flick_at, DBC + 1);
        check_eq("long_pulse_count", long_cnt, 1);
        check_eq("long_after_flick", long_at - flick_at, LPC - 1);
        check_eq("flick_long_overlap", overlap, 0);
        check_eq("long_end_state", int'(dut_if.dbg_state), int'(ST_IDLE));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/flick_debounce.md
FLICK_DEBOUNCE -- requirements
Module: flick_debounce

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4: consecutive synchronized samples needed to accept a level change; legal range 2..255.
REQ-002 Parameter LONG_CYCLES, default 64: cycles in PRESSED before long_press fires; SHALL be greater than DEBOUNCE_CYCLES and at most 65535.
REQ-003 clk  input  1: single clock; all logic rising-edge.
REQ-004 reset_n  input  1: reset, synchronous, active-low.
REQ-005 btn_raw  input  1: asynchronous, bouncing push-button level, active-high.
REQ-006 flick  output  1: one-cycle pulse per accepted press; drives the LED chaser's flick input.
REQ-007 long_press  output  1: one-cycle pulse when a press is held LONG_CYCLES cycles.
REQ-008 btn_level  output  1: debounced button level.
REQ-009 dbg_state  output  2: current FSM state, for bench probing.

Function
REQ-010 btn_raw SHALL pass through a 2-flop synchronizer; its output btn_s is the only form of the input used by the FSM.
REQ-011 The FSM SHALL have states IDLE=0, PRESS_WAIT=1, PRESSED=2, RELEASE_WAIT=3.
REQ-012 IDLE: btn_s=1 -> PRESS_WAIT with debounce counter = 1; otherwise stay, counter = 0.
REQ-013 PRESS_WAIT: btn_s=0 -> IDLE, counter = 0; btn_s=1 with counter = DEBOUNCE_CYCLES-1 -> PRESSED; otherwise counter increments.
REQ-014 flick SHALL be registered and high for exactly the one cycle after the PRESS_WAIT->PRESSED transition.
REQ-015 btn_raw held high with no bounce SHALL make flick rise after clock edge DEBOUNCE_CYCLES+1, counting the first edge that samples btn_raw=1 as edge 0.
REQ-016 Entering PRESSED from PRESS_WAIT SHALL clear the long-press counter to 0.
REQ-017 The long-press counter SHALL increment every cycle in PRESSED and saturate.
REQ-018 long_press SHALL pulse for one cycle when the long-press counter reaches LONG_CYCLES-1, at most once per accepted press.
REQ-019 PRESSED: btn_s=0 -> RELEASE_WAIT with debounce counter = 1.
REQ-020 RELEASE_WAIT: btn_s=1 -> PRESSED with no flick, and the long-press counter holds its value.
REQ-021 RELEASE_WAIT: btn_s=0 with counter = DEBOUNCE_CYCLES-1 -> IDLE; otherwise counter increments.
REQ-022 btn_level SHALL be 1 in PRESSED and RELEASE_WAIT and 0 in IDLE and PRESS_WAIT.
REQ-023 A bounce shorter than DEBOUNCE_CYCLES synchronized samples SHALL produce no flick and no btn_level change.
REQ-024 flick and long_press SHALL never be high in the same cycle.
REQ-025 Counter widths SHALL be derived from the parameters with $clog2, and no counter SHALL wrap.

Reset
REQ-026 reset_n=0 at a clock edge SHALL, at that edge, clear both synchronizer flops, both counters and all outputs to 0, and force state IDLE.
REQ-027 Reset asserted mid-operation in any state SHALL abort the operation with no flick or long_press pulse.
REQ-028 After reset release with btn_raw=1, the full debounce sequence SHALL be required before flick.

Structure
REQ-029 Package flick_pkg SHALL hold the state encoding constants and the default values of DEBOUNCE_CYCLES and LONG_CYCLES.
REQ-030 The synchronizer SHALL be a sub-module sync_2ff (clk, reset_n, d, q), reusable for other raw inputs.
REQ-031 The FSM and counters SHALL live in flick_debounce, with the state register and output registers in a single clocked process.

Verification
REQ-032 The bench SHALL use DEBOUNCE_CYCLES=4, LONG_CYCLES=16, a 10 ns clk period, and a flick_debounce output driving an Ex_1 instance.
REQ-033 Clean press: btn_raw 0->1 held 200 ns -> flick is high for one cycle after the 6th sampling edge, and btn_level=1 from the same cycle.
REQ-034 Bounce: btn_raw pulses 1 for 20 ns, 0 for 10 ns, 1 for 20 ns, then 0 -> flick never asserts and dbg_state never reaches 2.
REQ-035 Long hold: btn_raw held 1 for 300 ns -> exactly one flick, then exactly one long_press 15 cycles after flick, none afterwards.
REQ-036 Release glitch: while PRESSED, btn_raw=0 for 20 ns then back to 1 -> state goes 2->3->2, with no second flick and btn_level staying 1.
REQ-037 Mid-press reset: reset_n=0 for one edge while dbg_state=1 -> at that edge all outputs=0 and dbg_state=0; with btn_raw still 1, flick asserts 6 edges after reset_n returns to 1.
